// File: rtl/mc_sync_fifo.sv
// mc_sync_fifo: NUM_CH independent FIFOs sharing one memory array in the RClk domain.
// Each channel keeps its own pointers, level-decoded flags and sticky overflow/underflow.
module mc_sync_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4,
    parameter int NUM_CH        = 4,
    parameter int CH_BITS       = 2,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                                RClk,
    input  logic                                PresetFull,
    input  logic [NUM_CH-1:0]                   Clear_in,
    input  logic                                WriteEn_in,
    input  logic [CH_BITS-1:0]                  WrCh_in,
    input  logic [DATA_WIDTH-1:0]               Data_in,
    input  logic                                ReadEn_in,
    input  logic [CH_BITS-1:0]                  RdCh_in,
    output logic [DATA_WIDTH-1:0]               Data_out,
    output logic                                DataValid_out,
    output logic [NUM_CH-1:0]                   Full_out,
    output logic [NUM_CH-1:0]                   Empty_out,
    output logic [NUM_CH-1:0]                   AlmostFull_out,
    output logic [NUM_CH-1:0]                   AlmostEmpty_out,
    output logic [NUM_CH*(ADDRESS_WIDTH+1)-1:0] Level_out,
    output logic [NUM_CH-1:0]                   Overflow_out,
    output logic [NUM_CH-1:0]                   Underflow_out
);
    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam int LW    = ADDRESS_WIDTH + 1;

    logic [DATA_WIDTH-1:0]    r_mem [NUM_CH*DEPTH];
    logic [LW-1:0]            r_wptr [NUM_CH];
    logic [LW-1:0]            r_rptr [NUM_CH];
    logic [NUM_CH-1:0]        r_ovf, r_udf;
    logic [NUM_CH-1:0]        w_wsel, w_rsel, w_wacc, w_racc;
    logic [LW-1:0]            w_level [NUM_CH];
    logic [ADDRESS_WIDTH-1:0] w_wofs, w_rofs;

    assign Overflow_out  = r_ovf;
    assign Underflow_out = r_udf;

    genvar c;
    for (c = 0; c < NUM_CH; c = c + 1) begin : g_ch
        assign w_level[c]             = r_wptr[c] - r_rptr[c];
        assign Level_out[c*LW +: LW]  = w_level[c];
        assign Full_out[c]            = w_level[c] == LW'(DEPTH);
        assign Empty_out[c]           = w_level[c] == '0;
        assign AlmostFull_out[c]      = w_level[c] >= LW'(AFULL_THRESH);
        assign AlmostEmpty_out[c]     = w_level[c] <= LW'(AEMPTY_THRESH);
        // A cleared channel drops its requests before they can raise any flag.
        assign w_wsel[c] = WriteEn_in && WrCh_in == CH_BITS'(c) && !Clear_in[c];
        assign w_rsel[c] = ReadEn_in && RdCh_in == CH_BITS'(c) && !Clear_in[c];
        assign w_wacc[c] = w_wsel[c] && !Full_out[c];
        assign w_racc[c] = w_rsel[c] && !Empty_out[c];
    end

    always_comb begin
        w_wofs = '0;
        w_rofs = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_wsel[i]) w_wofs = r_wptr[i][ADDRESS_WIDTH-1:0];
            if (w_rsel[i]) w_rofs = r_rptr[i][ADDRESS_WIDTH-1:0];
        end
    end

    always_ff @(posedge RClk)
        if (|w_wacc) r_mem[{WrCh_in, w_wofs}] <= Data_in;

    always_ff @(posedge RClk or posedge PresetFull)
        if (PresetFull) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
            end
            r_ovf <= '0;
            r_udf <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (Clear_in[i]) begin
                    r_wptr[i] <= '0;
                    r_rptr[i] <= '0;
                    r_ovf[i]  <= 1'b0;
                    r_udf[i]  <= 1'b0;
                end else begin
                    if (w_wacc[i]) r_wptr[i] <= r_wptr[i] + LW'(1);
                    if (w_racc[i]) r_rptr[i] <= r_rptr[i] + LW'(1);
                    r_ovf[i] <= r_ovf[i] | (w_wsel[i] & Full_out[i]);
                    r_udf[i] <= r_udf[i] | (w_rsel[i] & Empty_out[i]);
                end
            end
        end

    always_ff @(posedge RClk or posedge PresetFull)
        if (PresetFull) begin
            Data_out      <= '0;
            DataValid_out <= 1'b0;
        end else begin
            DataValid_out <= |w_racc;
            if (|w_racc) Data_out <= r_mem[{RdCh_in, w_rofs}];
        end
endmodule
